// File: rtl/aec_expr_sender.sv
// ---------------------------------------------------------------------------
// aec_expr_sender
//   Transmit side of the AEC expression interface. A host appends ASCII
//   characters into a small buffer while the block is idle. On start the
//   buffered expression is streamed one character per cycle to an
//   AEC-compatible calculator, stopping after the first '='. The block then
//   waits for the calculator's valid strobe (or a timeout) and returns the
//   captured result and legality flag with a one-cycle done pulse.
//
// Ports
//   clk               in   rising-edge clock
//   rst               in   asynchronous active-low reset
//   wr_en / wr_char   in   append a character (accepted in IDLE when not full)
//   start             in   begin transmission (ignored when empty or busy)
//   full              out  buffer holds DEPTH characters
//   busy              out  high while sending or waiting for the result
//   ready             out  one-cycle pulse alongside the first character
//   ascii_out         out  character to the calculator (holds last one sent)
//   valid             in   calculator result strobe
//   result            in   calculator result
//   parenthesesLegal  in   calculator legality flag
//   done              out  one-cycle pulse: transaction finished
//   res_out           out  captured result, held until the next done
//   legal_out         out  captured legality, held until the next done
//   timeout_err       out  set with done when no result arrived in time
// ---------------------------------------------------------------------------
module aec_expr_sender #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_char,
    input  logic       start,
    output logic       full,
    output logic       busy,
    output logic       ready,
    output logic [7:0] ascii_out,
    input  logic       valid,
    input  logic [6:0] result,
    input  logic       parenthesesLegal,
    output logic       done,
    output logic [6:0] res_out,
    output logic       legal_out,
    output logic       timeout_err
);

    localparam int          CW = $clog2(DEPTH + 1);
    localparam int          WW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  EQ = 8'h3D;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    // Buffer is sized to the full index range so count/index never need
    // truncating when used as an address; entries >= DEPTH are never written.
    logic [7:0]    r_buf [2**CW];
    state_t        r_state, w_state;
    logic [CW-1:0] r_count, w_count;
    logic [CW-1:0] r_idx,   w_idx;
    logic          r_last,  w_last;   // character on ascii_out is the final one
    logic [WW-1:0] r_wcnt,  w_wcnt;
    logic          r_full,  w_full;
    logic          r_busy,  w_busy;
    logic          r_ready, w_ready;
    logic [7:0]    r_ascii, w_ascii;
    logic          r_done,  w_done;
    logic [6:0]    r_res,   w_res;
    logic          r_legal, w_legal;
    logic          r_tmo,   w_tmo;

    logic          w_we;
    logic [CW-1:0] w_cnt_wr;   // count after this cycle's write
    logic [7:0]    w_first;    // buf[0], bypassed when written this same cycle
    logic [CW-1:0] w_nidx;

    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_idx    = r_idx;
        w_last   = r_last;
        w_wcnt   = r_wcnt;
        w_busy   = r_busy;
        w_ready  = 1'b0;
        w_ascii  = r_ascii;
        w_done   = 1'b0;
        w_res    = r_res;
        w_legal  = r_legal;
        w_tmo    = r_tmo;
        w_we     = 1'b0;
        w_cnt_wr = r_count;
        w_first  = r_buf[0];
        w_nidx   = r_idx + CW'(1);

        case (r_state)
            S_IDLE: begin
                w_we = wr_en && (r_count != CW'(DEPTH));
                if (w_we)
                    w_cnt_wr = r_count + CW'(1);
                w_count = w_cnt_wr;
                if (w_we && (r_count == '0))
                    w_first = wr_char;
                // start sees the count including a write in the same cycle
                if (start && (w_cnt_wr != '0)) begin
                    w_state = S_SEND;
                    w_busy  = 1'b1;
                    w_ready = 1'b1;
                    w_ascii = w_first;
                    w_idx   = '0;
                    w_last  = (w_cnt_wr == CW'(1)) || (w_first == EQ);
                end
            end

            S_SEND: begin
                if (valid) begin
                    // early response: abandon the rest of the expression
                    w_res   = result;
                    w_legal = parenthesesLegal;
                    w_tmo   = 1'b0;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_count = '0;
                    w_state = S_IDLE;
                end else if (r_last) begin
                    w_state = S_WAIT;
                    w_wcnt  = '0;
                end else begin
                    w_ascii = r_buf[w_nidx];
                    w_idx   = w_nidx;
                    w_last  = (w_nidx == (r_count - CW'(1))) || (r_buf[w_nidx] == EQ);
                end
            end

            S_WAIT: begin
                if (valid) begin
                    w_res   = result;
                    w_legal = parenthesesLegal;
                    w_tmo   = 1'b0;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_count = '0;
                    w_state = S_IDLE;
                end else if ((r_wcnt + WW'(1)) == WW'(TIMEOUT)) begin
                    // done lands exactly TIMEOUT cycles after the first WAIT cycle
                    w_tmo   = 1'b1;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_count = '0;
                    w_state = S_IDLE;
                end else begin
                    w_wcnt = r_wcnt + WW'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase

        w_full = (w_count == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_wcnt  <= '0;
            r_full  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_ascii <= '0;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_legal <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_count <= w_count;
            r_idx   <= w_idx;
            r_last  <= w_last;
            r_wcnt  <= w_wcnt;
            r_full  <= w_full;
            r_busy  <= w_busy;
            r_ready <= w_ready;
            r_ascii <= w_ascii;
            r_done  <= w_done;
            r_res   <= w_res;
            r_legal <= w_legal;
            r_tmo   <= w_tmo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**CW; i++)
                r_buf[i] <= '0;
        end else if (w_we) begin
            r_buf[r_count] <= wr_char;
        end
    end

    assign full        = r_full;
    assign busy        = r_busy;
    assign ready       = r_ready;
    assign ascii_out   = r_ascii;
    assign done        = r_done;
    assign res_out     = r_res;
    assign legal_out   = r_legal;
    assign timeout_err = r_tmo;

endmodule
